// File: rtl/bforge_apb_mem_slave_if.sv
// APB4 bus bundle between a requester and the blueForge memory completer.
interface bforge_apb_mem_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  psel;
  logic                  penable;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/bforge_apb_mem_slave.sv
// APB4 completer: byte-strobed word memory with programmable wait states,
// range/alignment checks, a read-only low region and error injection.
module bforge_apb_mem_slave #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned            DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
  parameter int unsigned            RO_WORDS   = 0
) (
  input  logic                       pclk,
  input  logic                       preset,
  bforge_apb_mem_slave_if.slave      apb,
  input  logic [3:0]                 wait_states,
  input  logic                       err_inject
);

  localparam int unsigned LSB   = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  wr_q;
  logic                  err_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Extra offset bit exposes addresses below BASE_ADDR as an underflow.
  logic [ADDR_WIDTH:0] offset_c;
  logic [ADDR_WIDTH:0] word_c;
  logic [IDX_W-1:0]    idx_c;
  logic                range_err_c;
  logic                misalign_c;
  logic                ro_hit_c;
  logic                err_c;

  assign offset_c    = {1'b0, apb.paddr} - {1'b0, BASE_ADDR};
  assign word_c      = offset_c >> LSB;
  assign idx_c       = word_c[IDX_W-1:0];
  assign range_err_c = offset_c[ADDR_WIDTH] || (word_c >= (ADDR_WIDTH+1)'(DEPTH));
  assign misalign_c  = (apb.paddr & ADDR_WIDTH'(STRB_WIDTH - 1)) != '0;

  if (RO_WORDS > 0) begin : g_ro
    assign ro_hit_c = word_c < (ADDR_WIDTH+1)'(RO_WORDS);
  end else begin : g_no_ro
    assign ro_hit_c = 1'b0;
  end

  assign err_c = range_err_c || misalign_c || (apb.pwrite && ro_hit_c) || err_inject;

  // Transfer FSM, registered response outputs and the storage array.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      apb.prdata  <= '0;
      apb.pready  <= 1'b0;
      apb.pslverr <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (apb.psel && !apb.penable) begin
            wr_q    <= apb.pwrite;
            err_q   <= err_c;
            idx_q   <= idx_c;
            wdata_q <= apb.pwdata;
            strb_q  <= apb.pstrb;
            cnt     <= wait_states;
            if (wait_states == 4'd0) begin
              state       <= RESP;
              apb.pready  <= 1'b1;
              apb.pslverr <= err_c;
              apb.prdata  <= (apb.pwrite || err_c) ? '0 : mem[idx_c];
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!apb.psel) begin
            state <= IDLE;
          end else if (cnt == 4'd1) begin
            state       <= RESP;
            apb.pready  <= 1'b1;
            apb.pslverr <= err_q;
            apb.prdata  <= (wr_q || err_q) ? '0 : mem[idx_q];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (!apb.psel || apb.penable) begin
            if (apb.psel && wr_q && !err_q) begin
              for (int i = 0; i < int'(STRB_WIDTH); i++)
                if (strb_q[i]) mem[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
            end
            state       <= IDLE;
            apb.pready  <= 1'b0;
            apb.pslverr <= 1'b0;
            apb.prdata  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bforge_apb_mem_slave.sv
// Randomised and directed bench for bforge_apb_mem_slave against an array model.
module tb_bforge_apb_mem_slave;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned RO    = 4;
  localparam logic [31:0] BASE  = 32'h1000;

  logic       pclk   = 1'b0;
  logic       preset = 1'b1;
  logic [3:0] wait_states;
  logic       err_inject;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] last_rdata;

  bforge_apb_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  bforge_apb_mem_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
    .BASE_ADDR(BASE), .RO_WORDS(RO)
  ) u_dut (
    .pclk        (pclk),
    .preset      (preset),
    .apb         (apb.slave),
    .wait_states (wait_states),
    .err_inject  (err_inject)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_err(input logic [31:0] a, input logic w, input logic inj);
    longint off;
    off = longint'(a) - longint'(BASE);
    if (off < 0) return 1'b1;
    if (off / 4 >= longint'(DEPTH)) return 1'b1;
    if (a % 4 != 0) return 1'b1;
    if (w && off / 4 < longint'(RO)) return 1'b1;
    return inj;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
  endtask

  task automatic go_idle();
    @(posedge pclk); #1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
  endtask

  task automatic setup(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int ws, input logic inj);
    @(posedge pclk); #1;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.paddr   = addr;
    apb.pwrite  = wr;
    apb.pwdata  = wdata;
    apb.pstrb   = strb;
    wait_states = 4'(ws);
    err_inject  = inj;
  endtask

  // Full transfer; expectations come from the array model and the address rules.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int ws, input logic inj, input logic chg);
    logic        e;
    logic [31:0] er;
    int          idx;
    int          n;
    e   = exp_err(addr, wr, inj);
    idx = e ? 0 : int'((addr - BASE) / 4);
    er  = (e || wr) ? 32'h0 : model[idx];
    setup(addr, wr, wdata, strb, ws, inj);
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    if (chg) begin
      wait_states = 4'd0;
      err_inject  = ~inj;
    end
    n = 0;
    while (apb.pready !== 1'b1 && n <= 20) begin
      check("wait_outputs", {31'h0, apb.pslverr, apb.prdata}, 64'h0);
      n++;
      @(posedge pclk); #1;
    end
    check("wait_cycles", 64'(n), 64'(ws));
    check("pslverr", 64'(apb.pslverr), 64'(e));
    check("prdata", 64'(apb.prdata), 64'(er));
    last_rdata = apb.prdata;
    if (wr && !e)
      for (int i = 0; i < 4; i++)
        if (strb[i]) model[idx][i*8 +: 8] = wdata[i*8 +: 8];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.paddr = '0; apb.pwrite = 1'b0;
    apb.pwdata = '0; apb.pstrb = '0; wait_states = '0; err_inject = 1'b0;
    clear_model();
    repeat (2) @(posedge pclk);
    #1;
    check("reset_outputs", {30'h0, apb.pready, apb.pslverr, apb.prdata}, 64'h0);
    preset = 1'b0;

    // Basic read and read-modify-write through strobes.
    xfer(BASE + 32'h0, 1'b0, 32'h0, 4'hF, 0, 1'b0, 1'b0);
    xfer(BASE + 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, 1'b0, 1'b0);
    xfer(BASE + 32'h10, 1'b1, 32'h000000AA, 4'h1, 0, 1'b0, 1'b0);
    xfer(BASE + 32'h10, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b0);
    check("plan_rmw", 64'(last_rdata), 64'hDEADBEAA);
    xfer(BASE + 32'h10, 1'b1, 32'h11111111, 4'h0, 1, 1'b0, 1'b0);
    xfer(BASE + 32'h10, 1'b0, 32'h0, 4'hF, 0, 1'b0, 1'b0);

    // Wait states are captured at setup.
    xfer(BASE + 32'h4, 1'b0, 32'h0, 4'h0, 5, 1'b0, 1'b1);

    // Range, alignment, read-only and injection rules.
    xfer(32'h0FFC, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b0);
    xfer(32'h1400, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b0);
    xfer(32'h1002, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b0);
    xfer(32'h13FC, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b0);
    xfer(BASE + 32'h8, 1'b1, 32'h55, 4'hF, 0, 1'b0, 1'b0);
    xfer(BASE + 32'h8, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b0);
    xfer(BASE + 32'h28, 1'b1, 32'hA5A5A5A5, 4'hF, 2, 1'b1, 1'b1);
    xfer(BASE + 32'h28, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b0);
    xfer(BASE + 32'h28, 1'b1, 32'h5A5A5A5A, 4'hF, 1, 1'b0, 1'b0);
    xfer(BASE + 32'h28, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b0);
    check("plan_word10", 64'(last_rdata), 64'h5A5A5A5A);

    // Abort: psel dropped during WAIT, no write, next transfer clean.
    setup(BASE + 32'h50, 1'b1, 32'hCAFEF00D, 4'hF, 3, 1'b0);
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    @(posedge pclk); #1;
    check("abort_pready", 64'(apb.pready), 64'h0);
    apb.psel = 1'b0; apb.penable = 1'b0;
    xfer(BASE + 32'h50, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b0);
    xfer(BASE + 32'h54, 1'b1, 32'h12345678, 4'hF, 0, 1'b0, 1'b0);

    // Async reset while a read response is being driven.
    setup(BASE + 32'h54, 1'b0, 32'h0, 4'h0, 0, 1'b0);
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    check("resp_rdata", 64'(apb.prdata), 64'h12345678);
    preset = 1'b1;
    #1;
    check("rst_resp_out", {30'h0, apb.pready, apb.pslverr, apb.prdata}, 64'h0);
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    clear_model();
    xfer(BASE + 32'h10, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b0);

    // Reset in the second WAIT cycle of a write drops it.
    setup(BASE + 32'h20, 1'b1, 32'hFEEDFACE, 4'hF, 3, 1'b0);
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b1;
    #1;
    check("rst_wait_out", {30'h0, apb.pready, apb.pslverr, apb.prdata}, 64'h0);
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    xfer(BASE + 32'h20, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b0);

    // Random traffic, mostly back-to-back, against the model.
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 11))
        0:       a = BASE - 32'(4 * $urandom_range(1, 4));
        1:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
        2:       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        3:       a = BASE + 32'(4 * $urandom_range(0, 7));
        default: a = BASE + 32'(4 * $urandom_range(0, 15));
      endcase
      xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bforge_apb_mem_slave.md
# bforge_apb_mem_slave

Parametrised APB4 completer model for the blueForge APB VIP: a byte-strobed word memory behind a full SETUP/ACCESS handshake. It adds runtime-programmable wait states, address-range and alignment checking, a read-only region and per-transfer error injection. It sits on the completer side of the APB interface in the VIP bench and acts as a self-contained target for requester sequences and protocol checks.

## Interface

- ADDR_WIDTH, 32: paddr width.
- DATA_WIDTH, 32: data width; legal values are 8, 16, 32 and 64.
- STRB_WIDTH, DATA_WIDTH/8: byte-lane count (derived; do not override).
- DEPTH, 256: number of DATA_WIDTH-bit words.
- BASE_ADDR, 0: byte address of word 0; must be STRB_WIDTH-aligned.
- RO_WORDS, 0: words [0, RO_WORDS) are read-only; must be ≤ DEPTH.

- pclk  in  1  clock; all logic on the rising edge.
- preset  in  1  asynchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- paddr  in  ADDR_WIDTH  byte address.
- pwrite  in  1  1 = write, 0 = read.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  STRB_WIDTH  write byte strobes.
- prdata  out  DATA_WIDTH  read data.
- pready  out  1  transfer completion.
- pslverr  out  1  error response.
- wait_states  in  4  access-phase wait cycles; sampled in SETUP.
- err_inject  in  1  force an error on this transfer; sampled in SETUP.

## Operation

- FSM states: IDLE, WAIT, RESP.
- IDLE
  - A setup phase is psel=1 with penable=0.
  - On setup, capture paddr, pwrite, pwdata, pstrb, wait_states and err_inject.
  - Compute the error flag (rules below).
  - Load the wait counter with wait_states.
  - Next state: RESP if wait_states=0, otherwise WAIT.
- WAIT
  - pready=0.
  - The counter decrements each cycle.
  - When the counter reaches 1, go to RESP.
- RESP
  - pready=1.
  - pslverr = captured error flag.
  - If psel&penable: a non-error write commits per byte (lane i updated iff pstrb[i]); then go to IDLE.
- Word index = (paddr − BASE_ADDR) >> log2(STRB_WIDTH).
  - Compute the offset at ADDR_WIDTH+1 bits so an underflow is detectable.
- The error flag is set if any of the following holds:
  - paddr < BASE_ADDR;
  - index ≥ DEPTH;
  - paddr[log2(STRB_WIDTH)-1:0] ≠ 0;
  - a write with index < RO_WORDS;
  - err_inject=1.
- Error transfers leave memory unchanged and return prdata=0.
- Reads return the stored word in RESP.
  - prdata=0 in every other state and for writes.
  - pstrb is ignored on reads.
- A write with pstrb=0 completes OKAY and changes nothing.
- Abort: if psel falls in WAIT or RESP, go to IDLE.
  - No write occurs and outputs return to their idle values.
- A captured value applies for the whole transfer; changes on wait_states or err_inject after SETUP have no effect.

## Timing

- Reset (preset=1, asynchronous): state=IDLE, pready=0, pslverr=0, prdata=0, all memory words cleared to 0.
  - Deassertion is synchronised by the bench, not by this block.
- Setup at cycle T → pready=1 at cycle T+1+wait_states. The transfer occupies 2+wait_states cycles.
- pready, pslverr and prdata are registered; they change only on pclk edges (or on preset).
- Write data is visible to a read issued in the setup phase immediately after the write's RESP cycle.
- Back-to-back transfers: a new setup in the cycle after RESP is accepted with no idle gap.
- Reset mid-transfer: the transfer is dropped, a pending write is not committed, and memory is cleared.
- Outside RESP: pslverr=0 and pready=0.

## Test plan

- Reset, then read 0x00 with wait_states=0 → pready high in cycle 2, prdata=0, pslverr=0.
- Write 0xDEADBEEF to 0x10 with pstrb=0xF, then write 0x000000AA to 0x10 with pstrb=0x1, then read 0x10 → 0xDEADBEAA, OKAY on all three.
- wait_states=5, read 0x04 → exactly 5 cycles with pready=0, then 1 cycle with pready=1.
  - Changing wait_states to 0 mid-transfer does not shorten it.
- With DEPTH=256 and BASE_ADDR=0x1000:
  - read 0x0FFC → pslverr=1, prdata=0;
  - read 0x1400 → pslverr=1, prdata=0;
  - read 0x1002 (misaligned) → pslverr=1, prdata=0;
  - read 0x13FC → OKAY.
- With RO_WORDS=4: write 0x55 to word 2 → pslverr=1, readback unchanged.
  - Write with err_inject=1 to word 10 → pslverr=1, no update.
  - Next write to word 10 → OKAY.
- Write to 0x20 with wait_states=3; assert preset in the second WAIT cycle → outputs 0 immediately.
  - After release, read 0x20 → 0.
- psel dropped in WAIT → return to IDLE, no write; the following transfer completes normally.
